// File: rtl/uart_bus_pkg.sv
// uart_bus_pkg: bus widths and arbiter state shared by the uart register port and its arbiter
package uart_bus_pkg;
  localparam int ADR_W = 2;
  localparam int SEL_W = 4;
  localparam int DAT_W = 32;
  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_e;
  typedef struct packed {
    logic [ADR_W-1:0] adr;
    logic [SEL_W-1:0] sel;
    logic             we;
    logic [DAT_W-1:0] dat;
  } req_t;
endpackage

// File: rtl/bus_watchdog.sv
// bus_watchdog: saturating cycle counter that flags a transaction left unacknowledged for TIMEOUT cycles
module bus_watchdog #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);
  localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LIM = CW'(TIMEOUT);
  logic [CW-1:0] cnt;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt <= '0;
    else if (clear_i) cnt <= '0;
    else if (enable_i && cnt != LIM) cnt <= cnt + 1'b1;
  end
  assign expired_o = (TIMEOUT != 0) && (cnt == LIM);
endmodule

// File: rtl/uart_bus_arbiter.sv
// uart_bus_arbiter: round-robin arbiter giving two masters one-at-a-time access to the uart register port
module uart_bus_arbiter
  import uart_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [ADR_W-1:0] m0_adr_i,
  input  logic [SEL_W-1:0] m0_sel_i,
  input  logic             m0_stb_i,
  input  logic             m0_we_i,
  input  logic [DAT_W-1:0] m0_dat_i,
  output logic [DAT_W-1:0] m0_dat_o,
  output logic             m0_ack_o,
  output logic             m0_err_o,
  input  logic [ADR_W-1:0] m1_adr_i,
  input  logic [SEL_W-1:0] m1_sel_i,
  input  logic             m1_stb_i,
  input  logic             m1_we_i,
  input  logic [DAT_W-1:0] m1_dat_i,
  output logic [DAT_W-1:0] m1_dat_o,
  output logic             m1_ack_o,
  output logic             m1_err_o,
  output logic [ADR_W-1:0] s_adr_o,
  output logic [SEL_W-1:0] s_sel_o,
  output logic             s_stb_o,
  output logic             s_we_o,
  output logic [DAT_W-1:0] s_dat_o,
  input  logic [DAT_W-1:0] s_dat_i,
  input  logic             s_ack_i
);
  state_e state, next;
  logic last, g0, g1, stb_x, ack_ok, expired, to, done;
  req_t req0, req1, req_g;
  assign req0 = {m0_adr_i, m0_sel_i, m0_we_i, m0_dat_i};
  assign req1 = {m1_adr_i, m1_sel_i, m1_we_i, m1_dat_i};
  assign g0 = state == GNT0;
  assign g1 = state == GNT1;
  assign stb_x = g0 ? m0_stb_i : g1 ? m1_stb_i : 1'b0;
  assign ack_ok = stb_x & s_ack_i;
  // an ack arriving on the expiry cycle completes the transfer normally
  assign to = stb_x & expired & ~s_ack_i;
  assign done = ack_ok | to;
  bus_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .clear_i  (~stb_x | done),
    .enable_i (stb_x),
    .expired_o(expired)
  );
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
      last  <= 1'b1;
    end else begin
      state <= next;
      last  <= next == GNT0 ? 1'b0 : next == GNT1 ? 1'b1 : last;
    end
  end
  // a finished or aborted grant hands over to a waiting peer first, otherwise re-grants a still-requesting owner
  always_comb begin
    next = state;
    if (state == IDLE)
      next = (m0_stb_i && (!m1_stb_i || last)) ? GNT0 : m1_stb_i ? GNT1 : IDLE;
    else if (!stb_x || done)
      next = (g0 ? m1_stb_i : m0_stb_i) ? (g0 ? GNT1 : GNT0) : stb_x ? state : IDLE;
  end
  always_comb begin
    req_g = g0 ? req0 : req1;
    s_stb_o = stb_x & ~to;
    {s_adr_o, s_sel_o, s_we_o, s_dat_o} = stb_x ? req_g : '0;
    m0_ack_o = g0 & done;
    m0_err_o = g0 & to;
    m0_dat_o = (g0 & ack_ok) ? s_dat_i : '0;
    m1_ack_o = g1 & done;
    m1_err_o = g1 & to;
    m1_dat_o = (g1 & ack_ok) ? s_dat_i : '0;
  end
endmodule

// File: tb/tb_uart_bus_arbiter.sv
// tb_uart_bus_arbiter: directed per-feature checks of the two-master uart bus arbiter with TIMEOUT=8
module tb_uart_bus_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] m0_adr, m1_adr, s_adr;
  logic [3:0] m0_sel, m1_sel, s_sel;
  logic m0_stb, m1_stb, m0_we, m1_we, s_stb, s_we, s_ack;
  logic [31:0] m0_wdat, m1_wdat, m0_rdat, m1_rdat, s_wdat, s_rdat;
  logic m0_ack, m1_ack, m0_err, m1_err;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_bus_arbiter #(.TIMEOUT(8)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .m0_adr_i(m0_adr), .m0_sel_i(m0_sel), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_dat_i(m0_wdat),
    .m0_dat_o(m0_rdat), .m0_ack_o(m0_ack), .m0_err_o(m0_err),
    .m1_adr_i(m1_adr), .m1_sel_i(m1_sel), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_dat_i(m1_wdat),
    .m1_dat_o(m1_rdat), .m1_ack_o(m1_ack), .m1_err_o(m1_err),
    .s_adr_o(s_adr), .s_sel_o(s_sel), .s_stb_o(s_stb), .s_we_o(s_we), .s_dat_o(s_wdat),
    .s_dat_i(s_rdat), .s_ack_i(s_ack)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    m0_adr = 0; m0_sel = 0; m0_stb = 0; m0_we = 0; m0_wdat = 0;
    m1_adr = 0; m1_sel = 0; m1_stb = 0; m1_we = 0; m1_wdat = 0;
    s_ack = 0; s_rdat = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    m0_stb = 1; s_ack = 1; s_rdat = 32'hFFFF_FFFF;
    #12;
    checks++; if (s_stb !== 1'b0) begin errors++; $display("FAIL reset_s_stb: got %0h expected 0", s_stb); end
    checks++; if (m0_ack !== 1'b0) begin errors++; $display("FAIL reset_m0_ack: got %0h expected 0", m0_ack); end
    checks++; if (m0_rdat !== 32'h0) begin errors++; $display("FAIL reset_m0_dat: got %h expected 0", m0_rdat); end
    idle_inputs();
    rst_n = 1;
    step();
  endtask

  task automatic test_write();
    step(); m0_stb = 1; m0_we = 1; m0_adr = 1; m0_sel = 4'hF; m0_wdat = 32'h41; #1;
    checks++; if (s_stb !== 1'b0) begin errors++; $display("FAIL write_idle_stb: got %0h expected 0", s_stb); end
    step(); #1;
    checks++; if (s_stb !== 1'b1) begin errors++; $display("FAIL write_stb: got %0h expected 1", s_stb); end
    checks++; if (s_wdat !== 32'h41) begin errors++; $display("FAIL write_dat: got %h expected 41", s_wdat); end
    checks++; if (s_adr !== 2'd1 || s_we !== 1'b1 || s_sel !== 4'hF) begin errors++; $display("FAIL write_fields: got adr %0d we %0d sel %h expected 1 1 f", s_adr, s_we, s_sel); end
    checks++; if (m0_ack !== 1'b0) begin errors++; $display("FAIL write_early_ack: got %0h expected 0", m0_ack); end
    step(); s_ack = 1; #1;
    checks++; if (m0_ack !== 1'b1 || m0_err !== 1'b0) begin errors++; $display("FAIL write_ack: got ack %0h err %0h expected 1 0", m0_ack, m0_err); end
    checks++; if (m1_ack !== 1'b0) begin errors++; $display("FAIL write_m1_ack: got %0h expected 0", m1_ack); end
    step(); idle_inputs(); #1;
    checks++; if (s_stb !== 1'b0 || m0_ack !== 1'b0) begin errors++; $display("FAIL write_release: got stb %0h ack %0h expected 0 0", s_stb, m0_ack); end
    step();
  endtask

  task automatic test_round_robin();
    step();
    m0_stb = 1; m0_we = 1; m0_adr = 0; m0_wdat = 32'h11;
    m1_stb = 1; m1_we = 1; m1_adr = 3; m1_wdat = 32'h22; #1;
    step(); #1;
    checks++; if (s_adr !== 2'd3 || s_wdat !== 32'h22) begin errors++; $display("FAIL rr_m1_first: got adr %0d dat %h expected 3 22", s_adr, s_wdat); end
    step(); s_ack = 1; #1;
    checks++; if (m1_ack !== 1'b1 || m0_ack !== 1'b0) begin errors++; $display("FAIL rr_m1_ack: got m1 %0h m0 %0h expected 1 0", m1_ack, m0_ack); end
    step(); m1_stb = 0; s_ack = 0; #1;
    checks++; if (s_stb !== 1'b1 || s_wdat !== 32'h11 || s_adr !== 2'd0) begin errors++; $display("FAIL rr_handover: got stb %0h dat %h adr %0d expected 1 11 0", s_stb, s_wdat, s_adr); end
    step(); s_ack = 1; #1;
    checks++; if (m0_ack !== 1'b1 || m1_ack !== 1'b0) begin errors++; $display("FAIL rr_m0_ack: got m0 %0h m1 %0h expected 1 0", m0_ack, m1_ack); end
    step(); idle_inputs();
    step();
  endtask

  task automatic test_read();
    step(); m1_stb = 1; m1_we = 0; m1_adr = 2; #1;
    step(); #1;
    checks++; if (s_stb !== 1'b1 || s_adr !== 2'd2 || s_we !== 1'b0) begin errors++; $display("FAIL read_fields: got stb %0h adr %0d we %0h expected 1 2 0", s_stb, s_adr, s_we); end
    step(); s_ack = 1; s_rdat = 32'h0000_00A5; #1;
    checks++; if (m1_rdat !== 32'hA5 || m1_ack !== 1'b1) begin errors++; $display("FAIL read_data: got dat %h ack %0h expected a5 1", m1_rdat, m1_ack); end
    checks++; if (m0_rdat !== 32'h0 || m0_ack !== 1'b0) begin errors++; $display("FAIL read_other: got dat %h ack %0h expected 0 0", m0_rdat, m0_ack); end
    step(); idle_inputs();
    step();
  endtask

  task automatic test_timeout(input logic late_ack);
    step(); m0_stb = 1; m0_we = 0; m0_adr = 1; s_rdat = 32'h5A; #1;
    for (int i = 1; i <= 8; i++) begin
      step(); #1;
      checks++; if (m0_ack !== 1'b0 || s_stb !== 1'b1) begin errors++; $display("FAIL to_wait%0d: got ack %0h stb %0h expected 0 1", i, m0_ack, s_stb); end
    end
    step(); s_ack = late_ack; #1;
    if (late_ack) begin
      checks++; if (m0_ack !== 1'b1 || m0_err !== 1'b0 || m0_rdat !== 32'h5A || s_stb !== 1'b1) begin errors++; $display("FAIL to_ack_wins: got ack %0h err %0h dat %h stb %0h expected 1 0 5a 1", m0_ack, m0_err, m0_rdat, s_stb); end
    end else begin
      checks++; if (m0_ack !== 1'b1 || m0_err !== 1'b1 || m0_rdat !== 32'h0 || s_stb !== 1'b0) begin errors++; $display("FAIL to_err: got ack %0h err %0h dat %h stb %0h expected 1 1 0 0", m0_ack, m0_err, m0_rdat, s_stb); end
    end
    step(); idle_inputs(); #1;
    checks++; if (s_stb !== 1'b0 || m0_ack !== 1'b0 || m0_err !== 1'b0) begin errors++; $display("FAIL to_release: got stb %0h ack %0h err %0h expected 0 0 0", s_stb, m0_ack, m0_err); end
    step();
  endtask

  task automatic test_abort();
    step(); m0_stb = 1; m0_adr = 1; #1;
    step(); #1;
    checks++; if (s_stb !== 1'b1) begin errors++; $display("FAIL abort_grant: got %0h expected 1", s_stb); end
    step(); m0_stb = 0; m1_stb = 1; m1_we = 1; m1_adr = 2; m1_wdat = 32'h33; s_ack = 1; #1;
    checks++; if (s_stb !== 1'b0 || m0_ack !== 1'b0 || m1_ack !== 1'b0) begin errors++; $display("FAIL abort_drop: got stb %0h m0 %0h m1 %0h expected 0 0 0", s_stb, m0_ack, m1_ack); end
    step(); s_ack = 0; #1;
    checks++; if (s_stb !== 1'b1 || s_adr !== 2'd2 || s_wdat !== 32'h33 || m1_ack !== 1'b0) begin errors++; $display("FAIL abort_next: got stb %0h adr %0d dat %h ack %0h expected 1 2 33 0", s_stb, s_adr, s_wdat, m1_ack); end
    step(); s_ack = 1; #1;
    checks++; if (m1_ack !== 1'b1) begin errors++; $display("FAIL abort_m1_ack: got %0h expected 1", m1_ack); end
    step(); idle_inputs();
    step();
  endtask

  task automatic test_back_to_back();
    step(); m1_stb = 1; m1_we = 1; m1_wdat = 32'h88; m1_adr = 3; #1;
    step(); #1;
    checks++; if (s_stb !== 1'b1 || s_wdat !== 32'h88) begin errors++; $display("FAIL rst_gnt1: got stb %0h dat %h expected 1 88", s_stb, s_wdat); end
    rst_n = 0; s_ack = 1; s_rdat = 32'hFF; m0_stb = 1; m0_we = 1; m0_wdat = 32'h77; m0_adr = 0; #1;
    checks++; if (s_stb !== 1'b0 || s_adr !== 2'd0 || s_wdat !== 32'h0 || m1_ack !== 1'b0 || m1_rdat !== 32'h0) begin errors++; $display("FAIL rst_async: got stb %0h adr %0d dat %h ack %0h rdat %h expected all 0", s_stb, s_adr, s_wdat, m1_ack, m1_rdat); end
    step(); rst_n = 1; s_ack = 0; #1;
    checks++; if (s_stb !== 1'b0) begin errors++; $display("FAIL rst_idle: got %0h expected 0", s_stb); end
    step(); #1;
    checks++; if (s_stb !== 1'b1 || s_wdat !== 32'h77) begin errors++; $display("FAIL rst_m0_first: got stb %0h dat %h expected 1 77", s_stb, s_wdat); end
    step(); s_ack = 1; #1;
    checks++; if (m0_ack !== 1'b1 || m1_ack !== 1'b0) begin errors++; $display("FAIL b2b_m0_ack: got m0 %0h m1 %0h expected 1 0", m0_ack, m1_ack); end
    step(); s_ack = 0; #1;
    checks++; if (s_stb !== 1'b1 || s_wdat !== 32'h88 || m0_ack !== 1'b0) begin errors++; $display("FAIL b2b_to_m1: got stb %0h dat %h ack %0h expected 1 88 0", s_stb, s_wdat, m0_ack); end
    step(); s_ack = 1; #1;
    checks++; if (m1_ack !== 1'b1 || m0_ack !== 1'b0) begin errors++; $display("FAIL b2b_m1_ack: got m1 %0h m0 %0h expected 1 0", m1_ack, m0_ack); end
    step(); m1_stb = 0; s_ack = 0; #1;
    checks++; if (s_stb !== 1'b1 || s_wdat !== 32'h77) begin errors++; $display("FAIL b2b_to_m0: got stb %0h dat %h expected 1 77", s_stb, s_wdat); end
    step(); s_ack = 1; #1;
    checks++; if (m0_ack !== 1'b1) begin errors++; $display("FAIL b2b_m0_ack2: got %0h expected 1", m0_ack); end
    step(); idle_inputs();
    step();
  endtask

  initial begin
    test_reset();
    test_write();
    test_round_robin();
    test_read();
    test_timeout(1'b0);
    test_timeout(1'b1);
    test_abort();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
